uart_frame_loader: RTL
======================

# uart_frame_loader

Sequences the UART receiver's byte stream into the SNN input-image RAM. Collects a fixed-length frame of bytes, writes each byte to consecutive RAM addresses, and issues a one-cycle start pulse to the SNN core. It then holds off further loading until the core reports completion. A frame-gap timeout resynchronises the loader when the host aborts mid-frame.

## Interface
- NUM_BYTES, 98: bytes per frame (784 input pixels, 1 bit each); legal range 2..128.
- TIMEOUT_CYC, 104167: idle cycles allowed between bytes inside a frame before abort (about 4 byte times at 19200 baud, 50 MHz); must fit in 17 bits.
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- rx_rdy  input  1  one-cycle pulse from UART receiver: rx_data holds a new byte.
- rx_data  input  8  received byte, valid when rx_rdy=1.
- core_done  input  1  one-cycle pulse from SNN core: inference finished, RAM may be overwritten.
- clr_ovr  input  1  clears the sticky overrun flag.
- ram_we  output  1  RAM write enable.
- ram_addr  output  7  RAM write address.
- ram_wdata  output  8  RAM write data.
- start  output  1  one-cycle pulse: frame complete, core may run.
- busy  output  1  high whenever state is not IDLE.
- frame_err  output  1  one-cycle pulse on timeout abort.
- overrun  output  1  sticky: a byte arrived while the core owned the RAM.

## Operation
- States: IDLE, LOAD, START, WAIT.
- IDLE: addr=0. On rx_rdy, write the byte at addr 0, set addr to 1, clear the timer, and go to LOAD.
- LOAD: on rx_rdy, write the byte at addr and clear the timer.
  - If addr==NUM_BYTES-1, go to START and set addr to 0.
  - Otherwise increment addr.
- LOAD with no rx_rdy: the timer increments. When the timer equals TIMEOUT_CYC-1, pulse frame_err, set addr to 0, and go to IDLE.
- START: start=1 for exactly one cycle, then go to WAIT.
- WAIT: ignore rx_rdy. Any rx_rdy sets overrun and the byte is dropped (no ram_we). On core_done, go to IDLE.
- ram_we = rx_rdy && (state==IDLE || state==LOAD). ram_we, ram_addr and ram_wdata are combinational from rx_rdy, the addr register and rx_data.
- overrun: set by rx_rdy in WAIT, cleared by clr_ovr. If both occur in the same cycle, set wins.
- core_done outside WAIT is ignored.
- Timer: 17-bit counter, held at 0 outside LOAD.

## Timing
- Reset values:
  - state=IDLE, addr=0, timer=0, overrun=0.
  - start=0, frame_err=0, busy=0, ram_we=0, ram_addr=0, ram_wdata follows rx_data.
- Write latency is 0: ram_we is asserted in the same cycle as rx_rdy.
- start is asserted in the cycle after the last byte's write cycle. busy rises the cycle after the first byte's rx_rdy.
- rx_rdy in the same cycle the timer reaches TIMEOUT_CYC-1: the byte is accepted and there is no abort.
- rx_rdy and core_done in the same WAIT cycle: the byte is dropped, overrun is set, and the next state is IDLE.
- rx_rdy in the START cycle: the byte is dropped and overrun is set.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded and no start is issued.
- addr never exceeds NUM_BYTES-1 and never wraps within a frame.

## Structure
- Shared package snn_pkg holds:
  - the loader state typedef (enum reg[1:0] {IDLE, LOAD, START, WAIT}, prefixed for uniqueness);
  - NUM_BYTES, TIMEOUT_CYC, and the baud-time constant 12'hA2D used by the UART blocks.
- One natural sub-module: frame_timer (17-bit counter with clr/en inputs and an expired output equal to count==TIMEOUT_CYC-1).
- The FSM, address counter and overrun flag stay in uart_frame_loader.

## Test plan
- Reset, then 98 rx_rdy pulses carrying bytes 0x00..0x61, spaced 20 cycles apart:
  - 98 writes with ram_addr=data;
  - start pulses once, one cycle after the 98th write;
  - busy=1 until core_done.
- With TIMEOUT_CYC=50, send 10 bytes, then stay silent:
  - frame_err pulses exactly 50 cycles after the last byte (timer 0..49), then busy=0;
  - the next byte is written at addr 0.
- During WAIT, send rx_rdy with 0xAA:
  - no ram_we, overrun=1;
  - clr_ovr clears it;
  - clr_ovr coincident with a new rx_rdy leaves overrun=1.
- core_done coincident with rx_rdy in WAIT:
  - byte dropped, overrun=1, state IDLE;
  - the following byte is written at addr 0.
- With TIMEOUT_CYC=50, rx_rdy arrives exactly at timer=49: the byte is written and there is no frame_err.
- Assert rst_n low after 40 bytes:
  - all outputs return to reset values and start never pulses;
  - a full 98-byte frame afterwards completes normally.

Source files
------------

// File: rtl/uart_frame_loader_pkg.sv
// Shared constants and the loader state type.
// The UART receiver, timer and loader blocks all import this package.
package snn_pkg;

    localparam int NUM_BYTES   = 98;
    localparam int TIMEOUT_CYC = 104167;
    localparam int TIMER_W     = 17;
    localparam int ADDR_W      = 7;

    localparam logic [11:0] BAUD_TIME = 12'hA2D;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_LOAD  = 2'd1,
        LDR_START = 2'd2,
        LDR_WAIT  = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/uart_frame_loader_if.sv
// Receiver/core-side signal bundle for the frame loader.
// The slave modport is the loader; the master modport drives it.
interface uart_frame_loader_if;
    import snn_pkg::*;

    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              core_done;
    logic              clr_ovr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              start;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    modport slave (
        input  rx_rdy, rx_data, core_done, clr_ovr,
        output ram_we, ram_addr, ram_wdata, start, busy, frame_err, overrun
    );

    modport master (
        output rx_rdy, rx_data, core_done, clr_ovr,
        input  ram_we, ram_addr, ram_wdata, start, busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_frame_loader_frame_timer.sv
// Inter-byte gap counter: counts enabled cycles, clr dominates,
// o_expired flags the last allowed idle cycle.
module frame_timer #(
    parameter int TIMEOUT_CYC = snn_pkg::TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    import snn_pkg::*;

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

    assign o_expired = (r_count == TIMER_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/uart_frame_loader.sv
// Loads one fixed-length frame of UART bytes into the SNN image RAM,
// kicks the core with start, then locks out loading until core_done.
module uart_frame_loader #(
    parameter int NUM_BYTES   = snn_pkg::NUM_BYTES,
    parameter int TIMEOUT_CYC = snn_pkg::TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_frame_loader_if.slave   bus
);
    import snn_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

    ldr_state_t        r_state;
    ldr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_ovr;
    logic              w_accept;
    logic              w_drop;
    logic              w_start;
    logic              w_frame_err;
    logic              w_expired;
    logic              w_timer_clr;
    logic              w_timer_en;

    // Clearing on expiry keeps the count at zero once the FSM is back in IDLE.
    assign w_timer_en  = (r_state == LDR_LOAD);
    assign w_timer_clr = (r_state != LDR_LOAD) || bus.rx_rdy || w_expired;

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_timer_clr),
        .i_en      (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LDR_IDLE;
            r_addr  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_start     = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            LDR_IDLE: begin
                w_addr_nxt = '0;
                if (bus.rx_rdy) begin
                    w_accept    = 1'b1;
                    w_addr_nxt  = ADDR_W'(1);
                    w_state_nxt = LDR_LOAD;
                end
            end
            LDR_LOAD: begin
                // A byte on the expiry cycle wins over the abort.
                if (bus.rx_rdy) begin
                    w_accept = 1'b1;
                    if (r_addr == LAST_ADDR) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = LDR_START;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_W'(1);
                    end
                end else if (w_expired) begin
                    w_frame_err = 1'b1;
                    w_addr_nxt  = '0;
                    w_state_nxt = LDR_IDLE;
                end
            end
            LDR_START: begin
                w_start     = 1'b1;
                w_drop      = bus.rx_rdy;
                w_state_nxt = LDR_WAIT;
            end
            LDR_WAIT: begin
                w_drop = bus.rx_rdy;
                if (bus.core_done) begin
                    w_state_nxt = LDR_IDLE;
                end
            end
            default: begin
                w_addr_nxt  = '0;
                w_state_nxt = LDR_IDLE;
            end
        endcase
    end

    assign bus.ram_we    = w_accept;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = bus.rx_data;
    assign bus.start     = w_start;
    assign bus.busy      = (r_state != LDR_IDLE);
    assign bus.frame_err = w_frame_err;
    assign bus.overrun   = r_ovr;
endmodule
